// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator for RV32/RV64 (I/S/B/J/U/shamt).
// Registered output behind valid/ready, with an optional 2-entry skid buffer.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int SKID  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      instr,
  input  logic [2:0]       immsrc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  immext,
  output logic [TAG_W-1:0] out_tag,
  output logic             illegal
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } item_t;

  logic [31:7] ins;
  assign ins = instr;

  logic [31:0] v_i;
  logic [31:0] v_s;
  logic [31:0] v_b;
  logic [31:0] v_j;
  logic [31:0] v_u;
  logic [XLEN-1:0] v_sh;

  assign v_i = {{20{ins[31]}}, ins[31:20]};
  assign v_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign v_b = {{19{ins[31]}}, ins[31], ins[7],
                ins[30:25], ins[11:8], 1'b0};
  assign v_j = {{11{ins[31]}}, ins[31], ins[19:12],
                ins[20], ins[30:21], 1'b0};
  assign v_u = {ins[31:12], 12'b0};

  // RV64 shift amounts carry one extra bit
  assign v_sh = (XLEN == 64) ? XLEN'(ins[25:20])
                             : XLEN'(ins[24:20]);

  logic sel_i;
  logic sel_s;
  logic sel_b;
  logic sel_j;
  logic sel_u;
  logic sel_sh;

  assign sel_i  = (immsrc == 3'b000);
  assign sel_s  = (immsrc == 3'b001);
  assign sel_b  = (immsrc == 3'b010);
  assign sel_j  = (immsrc == 3'b011);
  assign sel_u  = (immsrc == 3'b100);
  assign sel_sh = (immsrc == 3'b101);

  item_t nxt;

  always_comb begin
    nxt     = '0;
    nxt.tag = in_tag;
    unique case (1'b1)
      sel_i:   nxt.imm = XLEN'($signed(v_i));
      sel_s:   nxt.imm = XLEN'($signed(v_s));
      sel_b:   nxt.imm = XLEN'($signed(v_b));
      sel_j:   nxt.imm = XLEN'($signed(v_j));
      sel_u:   nxt.imm = XLEN'($signed(v_u));
      sel_sh:  nxt.imm = v_sh;
      default: nxt.ill = 1'b1;
    endcase
  end

  logic  out_v;
  item_t out_q;
  logic  in_fire;
  logic  out_fire;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_v && out_ready;

  if (SKID != 0) begin : g_skid
    logic  skid_v;
    logic  rdy_q;
    item_t skid_q;

    assign in_ready = rdy_q;

    // skid only fills while out reg is full and stalled
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        out_v  <= 1'b0;
        out_q  <= '0;
        skid_v <= 1'b0;
        skid_q <= '0;
        rdy_q  <= 1'b1;
      end else if (out_fire) begin
        if (skid_v) begin
          out_q  <= skid_q;
          skid_v <= 1'b0;
          rdy_q  <= 1'b1;
        end else if (in_fire) begin
          out_q <= nxt;
        end else begin
          out_v <= 1'b0;
        end
      end else if (in_fire) begin
        if (!out_v) begin
          out_q <= nxt;
          out_v <= 1'b1;
        end else begin
          skid_q <= nxt;
          skid_v <= 1'b1;
          rdy_q  <= 1'b0;
        end
      end
    end
  end else begin : g_noskid
    assign in_ready = !out_v || out_ready;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        out_v <= 1'b0;
        out_q <= '0;
      end else if (in_fire) begin
        out_q <= nxt;
        out_v <= 1'b1;
      end else if (out_fire) begin
        out_v <= 1'b0;
      end
    end
  end

  assign out_valid = out_v;
  assign immext    = out_q.imm;
  assign out_tag   = out_q.tag;
  assign illegal   = out_q.ill;

endmodule
